// File: rtl/ex_div_unit.sv
// Iterative 32-bit signed/unsigned restoring divider for the EX stage.
// While a division is in flight it raises the EX stall request. Results are registered on entry to DONE.
module ex_div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        annul,
    output logic        stallreq_div,
    output logic        result_valid,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    typedef enum logic [1:0] {StIdle, StDivZero, StOn, StDone} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] dsor_q, dsor_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic        valid_q, valid_d;

    logic [31:0] a_abs, b_abs;
    logic [64:0] shifted, iter;

    always_comb begin
        a_abs   = (div_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
        b_abs   = (div_signed && divisor[31]) ? (~divisor + 32'd1) : divisor;
        shifted = work_q << 1;
        iter    = shifted;
        if (shifted[64:32] >= {1'b0, dsor_q}) begin
            iter[64:32] = shifted[64:32] - {1'b0, dsor_q};
            iter[0]     = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        dsor_d  = dsor_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (div_start) begin
                    cnt_d   = 6'd0;
                    dsor_d  = b_abs;
                    q_neg_d = div_signed & (dividend[31] ^ divisor[31]);
                    r_neg_d = div_signed & dividend[31];
                    if (divisor == 32'd0) begin
                        // Keep the raw dividend: it is returned as-is for divide-by-zero.
                        state_d = StDivZero;
                        work_d  = {33'd0, dividend};
                    end else begin
                        state_d = StOn;
                        work_d  = {33'd0, a_abs};
                    end
                end
            end
            StDivZero: begin
                state_d = StDone;
                valid_d = 1'b1;
                quot_d  = 32'hFFFF_FFFF;
                rem_d   = work_q[31:0];
            end
            StOn: begin
                work_d = iter;
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = StDone;
                    valid_d = 1'b1;
                    quot_d  = q_neg_q ? (~iter[31:0] + 32'd1) : iter[31:0];
                    rem_d   = r_neg_q ? (~iter[63:32] + 32'd1) : iter[63:32];
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (annul) begin
            state_d = StIdle;
            valid_d = 1'b0;
            quot_d  = quot_q;
            rem_d   = rem_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= 6'd0;
            work_q  <= 65'd0;
            dsor_q  <= 32'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            quot_q  <= 32'd0;
            rem_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            dsor_q  <= dsor_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
        end
    end

    assign stallreq_div = !annul && ((state_q == StIdle && div_start) ||
                                     state_q == StDivZero || state_q == StOn);
    assign result_valid = valid_q;
    assign quotient     = quot_q;
    assign remainder    = rem_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed self-checking bench for ex_div_unit: timing of stall/valid and hand-computed results.
module tb_ex_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        div_start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic        stallreq_div;
    logic        result_valid;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int checks = 0;
    int errors = 0;

    ex_div_unit dut (
        .clk          (clk),
        .resetn       (resetn),
        .div_start    (div_start),
        .div_signed   (div_signed),
        .dividend     (dividend),
        .divisor      (divisor),
        .annul        (annul),
        .stallreq_div (stallreq_div),
        .result_valid (result_valid),
        .quotient     (quotient),
        .remainder    (remainder)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance into the next cycle; state is settled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Starts in cycle T; returns in the DONE cycle with div_start dropped.
    task automatic do_div(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input int n_stall,
                          input logic [31:0] exp_q, input logic [31:0] exp_r);
        int bad;
        bad        = 0;
        div_start  = 1'b1;
        div_signed = s;
        dividend   = a;
        divisor    = b;
        #1;
        chk({tag, " stall@T"}, {31'd0, stallreq_div}, 32'd1);
        for (int i = 1; i < n_stall; i++) begin
            cyc();
            div_start = 1'b0;
            #1;
            if (stallreq_div !== 1'b1 || result_valid !== 1'b0) bad++;
        end
        chk({tag, " stall window"}, bad, 32'd0);
        cyc();
        #1;
        chk({tag, " valid"}, {31'd0, result_valid}, 32'd1);
        chk({tag, " stall@done"}, {31'd0, stallreq_div}, 32'd0);
        chk({tag, " quotient"}, quotient, exp_q);
        chk({tag, " remainder"}, remainder, exp_r);
    endtask

    initial begin
        int bad;
        resetn     = 1'b0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        dividend   = 32'd0;
        divisor    = 32'd0;
        annul      = 1'b0;
        cyc();
        cyc();
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        chk("reset valid", {31'd0, result_valid}, 32'd0);
        chk("reset stall", {31'd0, stallreq_div}, 32'd0);
        resetn = 1'b1;
        cyc();

        do_div("u100/7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2);
        cyc();
        do_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        cyc();
        do_div("u0xfffffff9/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 33, 32'h7FFF_FFFC, 32'd1);
        cyc();
        do_div("u/0", 1'b0, 32'h1234_5678, 32'd0, 2, 32'hFFFF_FFFF, 32'h1234_5678);
        cyc();
        do_div("s/0", 1'b1, 32'h8000_0001, 32'd0, 2, 32'hFFFF_FFFF, 32'h8000_0001);
        cyc();
        do_div("s min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
        cyc();
        do_div("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1);
        cyc();
        do_div("s-100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, 32'd14, 32'hFFFF_FFFE);
        cyc();
        do_div("u max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 32'd0);
        cyc();
        do_div("u5/9", 1'b0, 32'd5, 32'd9, 33, 32'd0, 32'd5);
        cyc();

        // Annul at T+10, restart at T+11.
        div_start  = 1'b1;
        div_signed = 1'b0;
        dividend   = 32'd100;
        divisor    = 32'd7;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            div_start = 1'b0;
        end
        annul = 1'b1;
        #1;
        chk("annul stall", {31'd0, stallreq_div}, 32'd0);
        cyc();
        annul = 1'b0;
        #1;
        chk("annul no valid", {31'd0, result_valid}, 32'd0);
        chk("annul q held", quotient, 32'd0);
        chk("annul r held", remainder, 32'd5);
        do_div("after annul", 1'b0, 32'hDEAD_BEEF, 32'h10, 33, 32'h0DEA_DBEE, 32'hF);

        // Back-to-back: a start held through DONE must be ignored.
        cyc();
        do_div("b2b first", 1'b0, 32'd1000, 32'd10, 33, 32'd100, 32'd0);
        div_start  = 1'b1;
        div_signed = 1'b1;
        dividend   = 32'hFFFF_FC18;
        divisor    = 32'd3;
        #1;
        chk("b2b stall in done", {31'd0, stallreq_div}, 32'd0);
        cyc();
        do_div("b2b second", 1'b1, 32'hFFFF_FC18, 32'd3, 33, 32'hFFFF_FEB3, 32'hFFFF_FFFF);

        // Reset mid-operation at T+5.
        cyc();
        div_start  = 1'b1;
        div_signed = 1'b0;
        dividend   = 32'd100;
        divisor    = 32'd7;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            div_start = 1'b0;
        end
        resetn = 1'b0;
        #1;
        chk("midreset quotient", quotient, 32'd0);
        chk("midreset remainder", remainder, 32'd0);
        chk("midreset stall", {31'd0, stallreq_div}, 32'd0);
        chk("midreset valid", {31'd0, result_valid}, 32'd0);
        cyc();
        resetn = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (result_valid !== 1'b0 || stallreq_div !== 1'b0) bad++;
        end
        chk("no result after reset", bad, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
